// File: rtl/sdp_ram_pkg.sv
// sdp_ram_pkg -- shared types and helpers for the simple dual-port RAM slice.
//
// Contents:
//   state_t   : clear-sequencer states (ST_CLEAR, ST_RUN)
//   RD_FIRST  : collision mode, read returns the previous word
//   WR_FIRST  : collision mode, read returns the data being written
//   par_of()  : even parity (XOR reduce) of a data word, up to 32 bits
//
// The optional parity bit is controlled by the macro SDP_RAM_PARITY_EN,
// which is consumed by sdp_ram_param.
package sdp_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;

  // Callers zero-extend narrower words; zero bits do not change the parity.
  function automatic logic par_of(input logic [31:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sdp_ram_clear_seq.sv
// sdp_ram_clear_seq -- post-reset memory-clear sequencer for sdp_ram_param.
//
// After reset it walks every address once, asserting clr_we with clr_addr,
// then settles in RUN and raises ready. With CLEAR_ON_RESET=0 it goes
// straight to RUN and ready rises on the first edge after reset.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high; restarts the walk at address 0
//   clr_we   out  clear write strobe (writes zero to clr_addr)
//   clr_addr out  address being cleared (the clear counter)
//   ready    out  registered; high when user accesses are accepted
//   state    out  current FSM state, for observation only
module sdp_ram_clear_seq
  import sdp_ram_pkg::*;
#(
  parameter int ADDR_W         = 13,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready,
  output state_t            state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Registered from the next state so ready is high in exactly the
      // cycles the FSM sits in RUN, and low while reset is held.
      ready_q <= (state_d == ST_RUN);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we = ~reset;
        // Counter wraps back to 0 after the last address, leaving it at
        // its reset value while in RUN.
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) state_d = ST_RUN;
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign clr_addr = cnt_q;
  assign ready    = ready_q;
  assign state    = state_q;

endmodule

// File: rtl/sdp_ram_param.sv
// sdp_ram_param -- parametrised single-clock simple dual-port RAM
// (write port A, read port B), inferable onto block RAM.
//
// Parameters:
//   DATA_W          data width (1..32)
//   ADDR_W          address width, DEPTH = 2**ADDR_W
//   OUT_REG         0: read latency 1; 1: latency 2 via oce-gated output reg
//   BYPASS          RD_FIRST (0) or WR_FIRST (1) on same-address collision
//   CLEAR_ON_RESET  1: zero all words after reset before raising ready
//
// Macro: SDP_RAM_PARITY_EN adds one even-parity bit per word and drives
// par_err on reads whose stored parity disagrees with the data. Undefined,
// the array is DATA_W wide and par_err is tied 0.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   cea, ada, din     write enable / address / data
//   ceb, adb          read enable / address
//   oce               output register enable (OUT_REG=1 only)
//   dout, dout_valid  read data and its one-cycle valid pulse
//   ready             user accesses accepted
//   par_err           parity error, only with dout_valid
//
// Handshake: cea/ceb are sampled only on edges where ready=1; accesses
// presented while ready=0 are dropped, never queued. Every read accepted
// produces exactly one dout_valid pulse (OUT_REG=0: after the next edge;
// OUT_REG=1: after the edge after that, unless oce=0 on that edge, in which
// case the read is discarded and dout holds). There is no backpressure.
module sdp_ram_param
  import sdp_ram_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 13,
  parameter int OUT_REG        = 1,
  parameter int BYPASS         = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cea,
  input  logic [ADDR_W-1:0] ada,
  input  logic [DATA_W-1:0] din,
  input  logic              ceb,
  input  logic [ADDR_W-1:0] adb,
  input  logic              oce,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              ready,
  output logic              par_err
);

  localparam int DEPTH = 1 << ADDR_W;
`ifdef SDP_RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  logic [MEM_W-1:0]  mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  // Sequencer state is carried out for checkers to bind to.
  state_t            unused_seq_state;

  sdp_ram_clear_seq #(
    .ADDR_W         (ADDR_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clr (
    .clk      (clk),
    .reset    (reset),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .ready    (ready),
    .state    (unused_seq_state)
  );

  logic              user_we, user_re, collide;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [MEM_W-1:0]  din_word, wd;

  assign user_we = ready & cea;
  assign user_re = ready & ceb;

`ifdef SDP_RAM_PARITY_EN
  assign din_word = {par_of(32'(din)), din};
`else
  assign din_word = din;
`endif

  // ready is low throughout CLEAR, so clear and user writes never overlap.
  always_comb begin
    we = clr_we | user_we;
    wa = clr_we ? clr_addr : ada;
    wd = clr_we ? '0 : din_word;
  end

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  // Read-first falls out of the non-blocking array read; write-first needs
  // an explicit forward of the incoming word.
  assign collide = (BYPASS == WR_FIRST) && user_we && user_re && (ada == adb);

  logic [MEM_W-1:0]  s1_word;
  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic              s1_perr;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_word  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= user_re;
      if (user_re) s1_word <= collide ? din_word : mem[adb];
    end
  end

  assign s1_data = s1_word[DATA_W-1:0];

`ifdef SDP_RAM_PARITY_EN
  assign s1_perr = s1_valid & (par_of(32'(s1_data)) != s1_word[DATA_W]);
`else
  assign s1_perr = 1'b0;
`endif

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] s2_data;
      logic              s2_valid;
      logic              s2_perr;

      // Only a valid stage-1 word is moved on, so a read discarded by
      // oce=0 never reappears in dout later.
      always_ff @(posedge clk) begin
        if (reset) begin
          s2_data  <= '0;
          s2_valid <= 1'b0;
          s2_perr  <= 1'b0;
        end else begin
          s2_valid <= oce & s1_valid;
          s2_perr  <= oce & s1_perr;
          if (oce && s1_valid) s2_data <= s1_data;
        end
      end

      assign dout       = s2_data;
      assign dout_valid = s2_valid;
      assign par_err    = s2_perr;
    end else begin : g_noreg
      logic oce_unused;
      assign oce_unused = oce;

      assign dout       = s1_data;
      assign dout_valid = s1_valid;
      assign par_err    = s1_perr;
    end
  endgenerate

endmodule

// File: tb/tb_sdp_ram_param.sv
// tb_sdp_ram_param -- directed bench for sdp_ram_param.
// Two instances share the input stimulus: dut_a (OUT_REG=0, read-first)
// and dut_b (OUT_REG=1, write-first), both 16 words x 8 bits with clear
// on reset. Expected reads are pushed as {par_err, data} when issued and
// popped by a monitor whenever a dout_valid pulse appears.
module tb_sdp_ram_param;

  localparam int DW = 8;
  localparam int AW = 4;

  // ---------------- clock / reset / signals ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cea = 1'b0, ceb = 1'b0, oce = 1'b1;
  logic [AW-1:0] ada = '0, adb = '0;
  logic [DW-1:0] din = '0;

  logic [DW-1:0] dout_a, dout_b;
  logic          valid_a, valid_b, ready_a, ready_b, perr_a, perr_b;

  always #5 clk = ~clk;

  sdp_ram_param #(
    .DATA_W(DW), .ADDR_W(AW), .OUT_REG(0), .BYPASS(0), .CLEAR_ON_RESET(1)
  ) dut_a (
    .clk(clk), .reset(reset), .cea(cea), .ada(ada), .din(din),
    .ceb(ceb), .adb(adb), .oce(oce), .dout(dout_a), .dout_valid(valid_a),
    .ready(ready_a), .par_err(perr_a)
  );

  sdp_ram_param #(
    .DATA_W(DW), .ADDR_W(AW), .OUT_REG(1), .BYPASS(1), .CLEAR_ON_RESET(1)
  ) dut_b (
    .clk(clk), .reset(reset), .cea(cea), .ada(ada), .din(din),
    .ceb(ceb), .adb(adb), .oce(oce), .dout(dout_b), .dout_valid(valid_b),
    .ready(ready_b), .par_err(perr_b)
  );

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int errors  = 0;
  logic [DW:0] exp_a[$];
  logic [DW:0] exp_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [DW:0] ea, input logic [DW:0] eb);
    exp_a.push_back(ea);
    exp_b.push_back(eb);
  endtask

  always @(negedge clk) begin
    if (valid_a) begin
      if (exp_a.size() == 0) check("a_spurious_valid", 32'(valid_a), 32'd0);
      else check("a_read", 32'({perr_a, dout_a}), 32'(exp_a.pop_front()));
    end
    if (valid_b) begin
      if (exp_b.size() == 0) check("b_spurious_valid", 32'(valid_b), 32'd0);
      else check("b_read", 32'({perr_b, dout_b}), 32'(exp_b.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic r, input logic we, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic re,
                      input logic [AW-1:0] ra, input logic oe);
    @(negedge clk);
    reset = r; cea = we; ada = wa; din = wd; ceb = re; adb = ra; oce = oe;
    @(posedge clk);
    #1;
  endtask

  task automatic rst();                                  step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1); endtask
  task automatic idle();                                 step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1); endtask
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d); step(1'b0, 1'b1, a, d, 1'b0, '0, 1'b1); endtask
  task automatic rd(input logic [AW-1:0] a);             step(1'b0, 1'b0, '0, '0, 1'b1, a, 1'b1); endtask

  // Counts edges after reset release until both instances are ready.
  task automatic wait_ready(input string name);
    int n = 0;
    while (!(ready_a && ready_b) && n < 40) begin
      idle();
      n++;
    end
    check(name, 32'(n), 32'd16);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst(); rst(); rst();
    check("rst_dout_a",  32'(dout_a),  32'd0);
    check("rst_valid_a", 32'(valid_a), 32'd0);
    check("rst_ready_a", 32'(ready_a), 32'd0);
    check("rst_perr_a",  32'(perr_a),  32'd0);
    check("rst_dout_b",  32'(dout_b),  32'd0);
    check("rst_valid_b", 32'(valid_b), 32'd0);
    check("rst_ready_b", 32'(ready_b), 32'd0);
    check("rst_perr_b",  32'(perr_b),  32'd0);

    // Clear takes 16 cycles, then every word reads zero.
    wait_ready("clear_len");
    for (int i = 0; i < 16; i++) begin
      push(9'h000, 9'h000);
      rd(AW'(i));
    end
    idle(); idle();

    // Write then read next cycle: latency 1 on a, 2 on b.
    wr(4'h3, 8'hA5);
    push(9'h0A5, 9'h0A5);
    rd(4'h3);
    check("lat1_a_valid", 32'(valid_a), 32'd1);
    check("lat1_a_dout",  32'(dout_a),  32'hA5);
    check("lat1_b_valid", 32'(valid_b), 32'd0);
    idle();
    check("lat2_a_valid", 32'(valid_a), 32'd0);
    check("lat2_b_valid", 32'(valid_b), 32'd1);
    check("lat2_b_dout",  32'(dout_b),  32'hA5);
    idle();

    // Collision at address 5: a returns old 0x11, b forwards 0x22.
    wr(4'h5, 8'h11);
    push(9'h011, 9'h022);
    step(1'b0, 1'b1, 4'h5, 8'h22, 1'b1, 4'h5, 1'b1);
    push(9'h022, 9'h022);
    rd(4'h5);
    idle(); idle();

    // Burst of reads 0..7 with oce low on the edge that would emit read 4.
    for (int i = 0; i < 8; i++) wr(AW'(i), DW'(8'h40 + i));
    for (int i = 0; i < 8; i++) begin
      exp_a.push_back(9'(8'h40 + i));
      if (i != 4) exp_b.push_back(9'(8'h40 + i));
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, '0, '0, 1'b1, AW'(i), (i != 5));
      if (i == 5) begin
        check("oce_drop_b_valid", 32'(valid_b), 32'd0);
        check("oce_hold_b_dout",  32'(dout_b),  32'h43);
      end
    end
    idle(); idle(); idle();

    // Reset pulsed mid-clear: counter restarts, CLEAR-time accesses dropped.
    rst();
    idle(); idle(); idle(); idle();
    wr(4'h9, 8'h99);
    rd(4'h9);
    idle();
    check("clr_cnt_at_7",   32'(dut_a.u_clr.clr_addr), 32'd7);
    check("clr_ready_low",  32'(ready_a), 32'd0);
    rst();
    check("clr_cnt_restart", 32'(dut_a.u_clr.clr_addr), 32'd0);
    wait_ready("clear_len_after_abort");
    push(9'h000, 9'h000);
    rd(4'h9);
    push(9'h000, 9'h000);
    rd(4'h3);
    idle(); idle(); idle();

`ifdef SDP_RAM_PARITY_EN
    // Corrupt data bit 0 of word 2 behind the parity bit's back.
    wr(4'h2, 8'h0F);
    idle();
    dut_a.mem[2][0] = ~dut_a.mem[2][0];
    dut_b.mem[2][0] = ~dut_b.mem[2][0];
    push(9'h10E, 9'h10E);
    rd(4'h2);
    push(9'h000, 9'h000);
    rd(4'h3);
    idle(); idle(); idle();
`endif

    check("exp_a_drained", 32'(exp_a.size()), 32'd0);
    check("exp_b_drained", 32'(exp_b.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
